dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the pipeline's MEM-stage load/store interface.
- Accepts one word request at a time over a valid/ready handshake and holds it for LATENCY cycles.
- Commits the write or performs the read, then returns a single-cycle response.
- Replaces the single-cycle data memory when the pipeline's memory stall path is exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, >= 4.
- LATENCY, 4, cycles from request acceptance to response; integer >= 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request this cycle.
- req_write_i  input  1  1 = store word, 0 = load word.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data.
- resp_valid_o  output  1  response valid; exactly one cycle per accepted request.
- resp_rdata_o  output  32  load data; 0 for stores and errors.
- resp_err_o  output  1  request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, req_ready_o=1 in the cycle after the reset edge, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, latency counter=0. Memory array is NOT cleared.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready_o=1.
  - If req_valid_i=1 at an edge, latch write, addr, wdata; load counter with LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - req_ready_o=0; inputs are ignored.
  - If counter=0, go to RESP at the next edge; otherwise decrement.
- Transition BUSY->RESP edge:
  - Error check: err = (addr[1:0]!=0) or ((addr>>2) >= DEPTH_WORDS).
  - Store with err=0: mem[addr>>2] <= wdata; rdata register <= 0.
  - Load with err=0: rdata register <= mem[addr>>2].
  - err=1: no memory update; rdata register <= 0.
  - Register err into resp_err_o.
- RESP:
  - resp_valid_o=1 for this one cycle; req_ready_o=0.
  - Unconditionally go to IDLE.
  - resp_rdata_o and resp_err_o hold their values until the next RESP entry; they are only meaningful while resp_valid_o=1.
- Timing: request accepted at edge N -> response visible in the cycle after edge N+LATENCY. The next request can be accepted at edge N+LATENCY+2 at the earliest; sustained throughput is 1 request per LATENCY+2 cycles.
- No response back-pressure: the requester must sample resp_valid_o when it is high.
- Reset mid-operation:
  - Reset in BUSY before the commit edge drops the transaction; no write, no response.
  - Reset asserted at the commit edge also suppresses the write.
  - Reset during RESP clears resp_valid_o at that edge.
- Simultaneous reset and req_valid_i: reset wins; the request is not accepted.
- Word index uses addr[log2(DEPTH_WORDS)+1:2]. Upper bits beyond the range flag an error; they never alias.

Test Plan:
- Store then load (LATENCY=4): store addr=0x10, wdata=0xDEADBEEF accepted at edge 0 -> resp_valid_o high for exactly one cycle after edge 4, resp_err_o=0, resp_rdata_o=0; then load addr=0x10 -> resp_rdata_o=0xDEADBEEF.
- Handshake: req_valid_i held high continuously with varying addresses -> req_ready_o low in BUSY/RESP; exactly one acceptance per 6 cycles; inputs changed during BUSY do not affect the result.
- Misaligned store to 0x13 -> resp_err_o=1, resp_rdata_o=0; a later load of word 0x10 still returns its prior value.
- Out of range (DEPTH_WORDS=256) load from 0x400 -> resp_err_o=1, resp_rdata_o=0; load from 0x3FC -> resp_err_o=0.
- Reset mid-operation: store 0x55AA55AA to 0x20, assert rst_i two cycles after acceptance -> no resp_valid_o pulse; a later load of 0x20 returns the old value; req_ready_o=1 in the cycle after the reset edge.
- LATENCY=1 boundary: load accepted at edge N -> resp_valid_o high in the cycle after edge N+1; back-to-back requests are accepted every 3 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the MEM-stage load/store interface. Accepts one word
//   request at a time over a valid/ready handshake. The request is held for
//   LATENCY cycles, then the store is committed or the load is read. A
//   single-cycle response follows.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   req_valid_i   request present
//   req_ready_o   responder idle and able to accept a request
//   req_write_i   1 = store word, 0 = load word
//   req_addr_i    byte address (must be word aligned and inside the array)
//   req_wdata_i   store data
//   resp_valid_o  one-cycle pulse per accepted request
//   resp_rdata_o  load data; 0 for stores and errored requests
//   resp_err_o    request was misaligned or out of range
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic             req_write_p0;
  logic [31:0]      req_addr_p0;
  logic [31:0]      req_wdata_p0;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             commit;
  logic             err_p0;
  logic [IDX_W-1:0] idx_p0;

  // Any set bit above the word index range is an error rather than an alias.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH_WORDS));
  endfunction

  assign req_ready_o  = (state == ST_IDLE);
  assign resp_valid_o = (state == ST_RESP);
  assign accept       = (state == ST_IDLE) && req_valid_i && !rst_i;
  assign commit       = (state == ST_BUSY) && (cnt == '0);
  assign err_p0       = addr_err(req_addr_p0);
  assign idx_p0       = req_addr_p0[IDX_W+1:2];

  // ---- request capture (p0): held stable for the whole BUSY window ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_write_p0 <= req_write_i;
      req_addr_p0  <= req_addr_i;
      req_wdata_p0 <= req_wdata_i;
    end
  end

  // ---- commit: store lands on the BUSY->RESP edge unless reset wins ----
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && req_write_p0 && !err_p0) begin
      mem[idx_p0] <= req_wdata_p0;
    end
  end

  // ---- control and response registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            cnt   <= CNT_LOAD;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state        <= ST_RESP;
            resp_err_o   <= err_p0;
            resp_rdata_o <= (!err_p0 && !req_write_p0) ? mem[idx_p0] : '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory contents per responder instance.
  logic [31:0] model [2][256];

  function automatic int lat_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 256);
  endfunction

  task automatic model_exec(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rd, output logic exp_er);
    exp_er = model_err(a);
    exp_rd = 32'h0;
    if (!exp_er) begin
      if (w) model[u][a / 4] = d;
      else   exp_rd = model[u][a / 4];
    end
  endtask

  // Issue one request from idle and wait (bounded) for its response.
  task automatic txn(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat, output logic after_v);
    @(negedge clk);
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a; req_wdata[u] = d;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0; req_write[u] = 1'($urandom); req_addr[u] = $urandom; req_wdata[u] = $urandom;
    lat = -1; rd = 'x; er = 1'bx;
    for (int k = 0; k < lat_of(u) + 6; k++) begin
      @(negedge clk);
      if (resp_valid[u]) begin
        lat = k; rd = resp_rdata[u]; er = resp_err[u];
        break;
      end
    end
    @(negedge clk);
    after_v = resp_valid[u];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      n_checks++; if (req_ready[u] !== 1'b1) $display("FAIL reset_ready[%0d] got %b exp 1", u, req_ready[u]); else n_pass++;
      n_checks++; if (resp_valid[u] !== 1'b0) $display("FAIL reset_valid[%0d] got %b exp 0", u, resp_valid[u]); else n_pass++;
      n_checks++; if (resp_rdata[u] !== 32'h0) $display("FAIL reset_rdata[%0d] got %h exp 0", u, resp_rdata[u]); else n_pass++;
      n_checks++; if (resp_err[u] !== 1'b0) $display("FAIL reset_err[%0d] got %b exp 0", u, resp_err[u]); else n_pass++;
    end
  endtask

  task automatic test_store_load();
    logic        w_t [2] = '{1'b1, 1'b0};
    logic [31:0] a_t [2] = '{32'h10, 32'h10};
    logic [31:0] d_t [2] = '{32'hDEADBEEF, 32'h0};
    logic [31:0] rd, erd; logic er, eer, av; int lat;
    for (int i = 0; i < 2; i++) begin
      model_exec(0, w_t[i], a_t[i], d_t[i], erd, eer);
      txn(0, w_t[i], a_t[i], d_t[i], rd, er, lat, av);
      n_checks++; if (lat !== 4) $display("FAIL store_load[%0d] latency got %0d exp 4", i, lat); else n_pass++;
      n_checks++; if (av !== 1'b0) $display("FAIL store_load[%0d] pulse_width valid_after got %b exp 0", i, av); else n_pass++;
      n_checks++; if (er !== eer) $display("FAIL store_load[%0d] err got %b exp %b", i, er, eer); else n_pass++;
      n_checks++; if (rd !== erd) $display("FAIL store_load[%0d] rdata got %h exp %h", i, rd, erd); else n_pass++;
    end
  endtask

  task automatic test_random(input int u);
    logic [31:0] a, d, rd, erd; logic w, er, eer, av; int lat, kind;
    for (int i = 0; i < 40; i++) begin
      if (i < 16) begin
        w = 1'b1; a = 32'(i * 4);
      end else begin
        w = 1'($urandom_range(0, 1));
        kind = $urandom_range(0, 7);
        if (kind == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (kind == 1) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
        else                a = 32'($urandom_range(0, 15) * 4);
      end
      d = $urandom;
      model_exec(u, w, a, d, erd, eer);
      txn(u, w, a, d, rd, er, lat, av);
      n_checks++; if (lat !== lat_of(u)) $display("FAIL random%0d[%0d] latency got %0d exp %0d", u, i, lat, lat_of(u)); else n_pass++;
      n_checks++; if (av !== 1'b0) $display("FAIL random%0d[%0d] valid_after got %b exp 0", u, i, av); else n_pass++;
      n_checks++; if (er !== eer) $display("FAIL random%0d[%0d] err addr=%h got %b exp %b", u, i, a, er, eer); else n_pass++;
      n_checks++; if (rd !== erd) $display("FAIL random%0d[%0d] rdata addr=%h got %h exp %h", u, i, a, rd, erd); else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic        w_t [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_t [8] = '{32'h13, 32'h10, 32'h400, 32'h3FC, 32'h3FC, 32'h8000_0010, 32'h10, 32'h402};
    logic [31:0] d, rd, erd; logic er, eer, av; int lat;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model_exec(0, w_t[i], a_t[i], d, erd, eer);
      txn(0, w_t[i], a_t[i], d, rd, er, lat, av);
      n_checks++; if (lat !== 4) $display("FAIL errors[%0d] latency got %0d exp 4", i, lat); else n_pass++;
      n_checks++; if (er !== eer) $display("FAIL errors[%0d] err addr=%h got %b exp %b", i, a_t[i], er, eer); else n_pass++;
      n_checks++; if (rd !== erd) $display("FAIL errors[%0d] rdata addr=%h got %h exp %h", i, a_t[i], rd, erd); else n_pass++;
    end
  endtask

  // req_valid held high with inputs changing every cycle.
  task automatic test_handshake(input int u);
    logic [32:0] expq[$];
    logic [32:0] e;
    logic [31:0] a, d, erd; logic w, eer;
    int acc = 0, rsp = 0, last_acc = -1;
    for (int cyc = 0; cyc < 80 && rsp < 4; cyc++) begin
      @(negedge clk);
      if (resp_valid[u]) begin
        n_checks++; if (req_ready[u] !== 1'b0) $display("FAIL hs%0d ready_in_resp got %b exp 0", u, req_ready[u]); else n_pass++;
        n_checks++;
        if (expq.size() == 0) $display("FAIL hs%0d spurious_resp got 1 exp 0", u);
        else begin
          e = expq.pop_front();
          if ({resp_err[u], resp_rdata[u]} !== e) $display("FAIL hs%0d resp got %h exp %h", u, {resp_err[u], resp_rdata[u]}, e);
          else n_pass++;
        end
        rsp++;
      end
      w = 1'($urandom_range(0, 1)); a = 32'($urandom_range(0, 15) * 4); d = $urandom;
      req_write[u] = w; req_addr[u] = a; req_wdata[u] = d; req_valid[u] = (acc < 4);
      if (req_ready[u] && acc < 4) begin
        model_exec(u, w, a, d, erd, eer);
        expq.push_back({eer, erd});
        if (last_acc >= 0) begin
          n_checks++; if (cyc - last_acc !== lat_of(u) + 2) $display("FAIL hs%0d accept_gap got %0d exp %0d", u, cyc - last_acc, lat_of(u) + 2); else n_pass++;
        end
        last_acc = cyc; acc++;
      end
    end
    req_valid[u] = 1'b0;
    n_checks++; if (rsp !== 4) $display("FAIL hs%0d responses got %0d exp 4", u, rsp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer, av, seen; int lat;
    // k_rst: number of negedges after acceptance before rst is raised
    int          k_t [3] = '{2, 4, 5};
    logic [31:0] a_t [3] = '{32'h20, 32'h24, 32'h2C};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = a_t[i]; req_wdata[0] = 32'h55AA55AA;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      repeat (k_t[i]) @(negedge clk);
      if (k_t[i] == 5) begin
        n_checks++; if (resp_valid[0] !== 1'b1) $display("FAIL rstmid[%0d] resp_before_rst got %b exp 1", i, resp_valid[0]); else n_pass++;
        model[0][a_t[i] / 4] = 32'h55AA55AA;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (req_ready[0] !== 1'b1) $display("FAIL rstmid[%0d] ready got %b exp 1", i, req_ready[0]); else n_pass++;
      n_checks++; if (resp_valid[0] !== 1'b0) $display("FAIL rstmid[%0d] valid got %b exp 0", i, resp_valid[0]); else n_pass++;
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (resp_valid[0]) seen = 1'b1; end
      n_checks++; if (seen !== 1'b0) $display("FAIL rstmid[%0d] late_resp got %b exp 0", i, seen); else n_pass++;
      model_exec(0, 1'b0, a_t[i], 32'h0, erd, eer);
      txn(0, 1'b0, a_t[i], 32'h0, rd, er, lat, av);
      n_checks++; if (rd !== erd) $display("FAIL rstmid[%0d] reload got %h exp %h", i, rd, erd); else n_pass++;
    end
    // Reset and request in the same cycle: reset wins.
    @(negedge clk);
    rst = 1'b1; req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h28; req_wdata[0] = 32'hA5A5_0F0F;
    @(negedge clk);
    rst = 1'b0; req_valid[0] = 1'b0;
    n_checks++; if (req_ready[0] !== 1'b1) $display("FAIL rst_vs_req ready got %b exp 1", req_ready[0]); else n_pass++;
    model_exec(0, 1'b0, 32'h28, 32'h0, erd, eer);
    txn(0, 1'b0, 32'h28, 32'h0, rd, er, lat, av);
    n_checks++; if (rd !== erd) $display("FAIL rst_vs_req reload got %h exp %h", rd, erd); else n_pass++;
  endtask

  task automatic test_latency1();
    test_random(1);
    test_handshake(1);
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 32'h0; req_wdata[u] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_random(0);
    test_errors();
    test_handshake(0);
    test_reset_mid();
    test_latency1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
